// File: rtl/ysyx_24100005_ifu.sv
// Multi-cycle instruction fetch unit: owns the PC, fetches one word per trip and hands it to the datapath.
// Define IFU_PERF_EN to build the fetch and memory-stall performance counters.
module ysyx_24100005_ifu #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            req_valid,
   input  logic            req_ready,
   output logic [XLEN-1:0] req_addr,
   input  logic            resp_valid,
   input  logic [31:0]     resp_rdata,
   input  logic            resp_err,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] npc,
   output logic            fetch_err,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_stall_cnt
);

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t state, state_nxt;
   logic   resp_fire;
   logic   inst_fire;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Handshake outputs come from the state alone, so no input reaches an output combinationally.
   always_comb begin
      state_nxt  = state;
      req_valid  = 1'b0;
      inst_valid = 1'b0;
      unique case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            req_valid = 1'b1;
            if (req_ready) state_nxt = WAIT;
         end
         WAIT: if (resp_valid) state_nxt = HOLD;
         HOLD: begin
            inst_valid = 1'b1;
            if (inst_ready) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req_addr  = pc;
   assign resp_fire = (state == WAIT) && resp_valid;
   assign inst_fire = (state == HOLD) && inst_ready;

   // A faulting fetch delivers ebreak; a misaligned npc is forced onto a word boundary.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc        <= RESET_PC;
         inst      <= '0;
         fetch_err <= 1'b0;
      end else begin
         if (resp_fire) inst <= resp_err ? EBREAK : resp_rdata;
         if (inst_fire) pc <= {npc[XLEN-1:2], 2'b00};
         if ((resp_fire && resp_err) || (inst_fire && (npc[1:0] != 2'b00))) fetch_err <= 1'b1;
      end
   end

`ifdef IFU_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (inst_fire) fetch_cnt <= fetch_cnt + 32'd1;
         if ((state == WAIT) && !resp_valid) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt;
   assign perf_stall_cnt = stall_cnt;
`else
   assign perf_fetch_cnt = 32'h0;
   assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Scoreboard bench for ysyx_24100005_ifu: a driver plays imem and datapath, a monitor checks each
// delivered instruction against the queue of expected {pc, inst} pairs.
module tb_ysyx_24100005_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] EBREAK   = 32'h0010_0073;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] npc;
   logic        fetch_err;
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;

   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   int          rel_cyc = 0;
   int          hold_cyc = 0;
   logic        exp_ferr = 1'b0;
   logic [63:0] sb_q[$];

   ysyx_24100005_ifu #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc), .npc(npc),
      .fetch_err(fetch_err), .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic apply_reset();
      rst        = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      resp_err   = 1'b0;
      inst_ready = 1'b0;
      npc        = '0;
      exp_ferr   = 1'b0;
      repeat (2) @(negedge clk);
      check_output("rst_req_valid", {31'd0, req_valid}, 32'd0);
      check_output("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check_output("rst_pc", pc, RESET_PC);
      check_output("rst_inst", inst, 32'd0);
      check_output("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
      check_output("rst_perf_fetch", perf_fetch_cnt, 32'd0);
      check_output("rst_perf_stall", perf_stall_cnt, 32'd0);
      rst     = 1'b1;
      rel_cyc = cyc;
   endtask

   // One complete fetch: request (optionally stalled), response after resp_stall idle WAIT cycles,
   // HOLD for hold_stall cycles (optionally with a stray response pulse), then accept with npc_val.
   task automatic apply_stimulus(input logic [31:0] exp_pc, input logic [31:0] rdata, input logic err,
                                 input int req_stall, input int resp_stall, input int hold_stall,
                                 input logic pulse, input logic [31:0] npc_val);
      int          n;
      logic [31:0] exp_inst;
      n = 0;
      while (!req_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_valid) begin
         checks++;
         $display("[TB] FAIL req_timeout: req_valid still 0 after %0d cycles, required 1", n);
         return;
      end
      check_output("req_addr", req_addr, exp_pc);
      check_output("fetch_err_req", {31'd0, fetch_err}, {31'd0, exp_ferr});
      for (int i = 0; i < req_stall; i++) begin
         req_ready = 1'b0;
         @(negedge clk);
         check_output("stall_req_valid", {31'd0, req_valid}, 32'd1);
         check_output("stall_req_addr", req_addr, exp_pc);
      end
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      check_output("wait_req_valid", {31'd0, req_valid}, 32'd0);
      repeat (resp_stall) @(negedge clk);
      resp_valid = 1'b1;
      resp_rdata = rdata;
      resp_err   = err;
      exp_inst   = err ? EBREAK : rdata;
      if (err) exp_ferr = 1'b1;
      sb_q.push_back({exp_pc, exp_inst});
      @(negedge clk);
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      hold_cyc   = cyc;
      check_output("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
      check_output("fetch_err_hold", {31'd0, fetch_err}, {31'd0, exp_ferr});
      for (int i = 0; i < hold_stall; i++) begin
         inst_ready = 1'b0;
         if (pulse && i == 1) begin
            resp_valid = 1'b1;
            resp_rdata = 32'hDEAD_BEEF;
         end
         @(negedge clk);
         resp_valid = 1'b0;
         check_output("hold_inst", inst, exp_inst);
         check_output("hold_pc", pc, exp_pc);
      end
      inst_ready = 1'b1;
      npc        = npc_val;
      @(negedge clk);
      inst_ready = 1'b0;
      if (npc_val[1:0] != 2'b00) exp_ferr = 1'b1;
   endtask

   // Monitor: every inst handshake must match the oldest expected entry.
   initial begin
      logic [63:0] exp;
      forever begin
         @(negedge clk);
         #2;
         if (rst && inst_valid && inst_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               $display("[TB] FAIL sb_unexpected: got inst %h pc %h, required no delivery", inst, pc);
            end else begin
               exp = sb_q.pop_front();
               check_output("sb_inst", inst, exp[31:0]);
               check_output("sb_pc", pc, exp[63:32]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] exp_cnt;
      apply_reset();
      apply_stimulus(32'h8000_0000, 32'h0000_0413, 1'b0, 0, 0, 0, 1'b0, 32'h8000_0004);
      check_output("first_latency", hold_cyc - rel_cyc, 32'd3);
      apply_stimulus(32'h8000_0004, 32'h0050_0093, 1'b0, 4, 0, 0, 1'b0, 32'h8000_0008);
      apply_stimulus(32'h8000_0008, 32'h00A0_0113, 1'b0, 0, 2, 5, 1'b1, 32'h8000_000C);
      apply_stimulus(32'h8000_000C, 32'h0020_81B3, 1'b0, 0, 0, 0, 1'b0, 32'h8000_0106);
      apply_stimulus(32'h8000_0104, 32'h0000_0013, 1'b0, 0, 0, 0, 1'b0, 32'h8000_0108);

      // Reset while WAIT is pending, then a stale response straddling the release.
      @(negedge clk);
      if (req_valid) begin
         req_ready = 1'b1;
         @(negedge clk);
         req_ready = 1'b0;
      end
      #3 rst = 1'b0;
      #1;
      check_output("arst_req_valid", {31'd0, req_valid}, 32'd0);
      check_output("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check_output("arst_req_addr", req_addr, RESET_PC);
      check_output("arst_inst", inst, 32'd0);
      check_output("arst_fetch_err", {31'd0, fetch_err}, 32'd0);
      exp_ferr = 1'b0;
      @(negedge clk);
      rst        = 1'b1;
      resp_valid = 1'b1;
      resp_rdata = 32'hDEAD_BEEF;
      resp_err   = 1'b1;
      repeat (2) @(negedge clk);
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      apply_stimulus(32'h8000_0000, 32'h0000_0013, 1'b0, 0, 0, 0, 1'b0, 32'h8000_0004);

      apply_stimulus(32'h8000_0004, 32'hFFFF_FFFF, 1'b1, 0, 1, 0, 1'b0, 32'h8000_0008);
      apply_stimulus(32'h8000_0008, 32'h0010_0093, 1'b0, 0, 0, 0, 1'b0, 32'h8000_000C);
      apply_stimulus(32'h8000_000C, 32'h0020_0113, 1'b0, 1, 0, 0, 1'b0, 32'h8000_0010);
      apply_stimulus(32'h8000_0010, 32'h0030_0193, 1'b0, 0, 0, 1, 1'b0, 32'h8000_0014);
      check_output("sticky_fetch_err", {31'd0, fetch_err}, 32'd1);

      apply_reset();
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(RESET_PC + 32'(4 * i), 32'h0000_0093 + 32'(i << 20), 1'b0, 0, 1, 0, 1'b0,
                        RESET_PC + 32'(4 * (i + 1)));
      end
`ifdef IFU_PERF_EN
      exp_cnt = 32'd10;
`else
      exp_cnt = 32'd0;
`endif
      check_output("perf_fetch_cnt", perf_fetch_cnt, exp_cnt);
      check_output("perf_stall_cnt", perf_stall_cnt, exp_cnt);

      repeat (3) @(negedge clk);
      check_output("sb_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_24100005_ifu.md
Name: ysyx_24100005_ifu

Overview:
Multi-cycle instruction fetch unit placed directly upstream of the core datapath. It owns the architectural PC and issues word reads to instruction memory over a valid/ready request channel. It captures the returned instruction word and presents inst/pc to the execute/decode stage through a valid/ready handshake. The next PC (npc) is taken from the datapath in the same cycle the instruction is accepted.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset
XLEN, 32, address/data width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
req_valid  output  1  fetch request valid to imem
req_ready  input  1  imem accepts request
req_addr  output  XLEN  fetch address (= pc)
resp_valid  input  1  imem read data valid
resp_rdata  input  32  fetched instruction word
resp_err  input  1  imem access fault, qualified by resp_valid
inst_valid  output  1  instruction valid to datapath
inst_ready  input  1  datapath accepts instruction
inst  output  32  instruction word
pc  output  XLEN  PC of inst
npc  input  XLEN  next PC, sampled on inst handshake
fetch_err  output  1  sticky fault flag
perf_fetch_cnt  output  32  retired-fetch counter (see Optional Feature)
perf_stall_cnt  output  32  memory-wait cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, inst=0, inst_valid=0, req_valid=0, fetch_err=0, counters=0. Takes effect immediately, including mid-request; any outstanding imem response arriving after reset release while not in WAIT is ignored.
- States: IDLE, REQ, WAIT, HOLD. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE: entered only from reset. First clock edge after reset release -> REQ.
- REQ: req_valid=1, req_addr=pc, held stable until req_valid&&req_ready. On handshake -> WAIT.
- WAIT: req_valid=0. Each cycle with resp_valid=0 increments perf_stall_cnt. On resp_valid=1: inst<=resp_rdata; if resp_err=1, fetch_err<=1 and inst<=32'h0010_0073 (ebreak) -> HOLD.
- resp_valid in IDLE, REQ or HOLD: ignored. The imem returns data no earlier than the cycle after the request handshake.
- HOLD: inst_valid=1; inst and pc held stable until inst_ready=1. On inst_valid&&inst_ready: pc<=npc, perf_fetch_cnt++ -> REQ.
- npc misaligned (npc[1:0]!=0) at handshake: pc<={npc[XLEN-1:2],2'b00}, fetch_err<=1.
- fetch_err is sticky until reset.
- Minimum throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD, each one cycle).
- Counters wrap modulo 2^32 without a flag.

Optional Feature:
IFU_PERF_EN. When defined, perf_fetch_cnt and perf_stall_cnt count as described above. When undefined, both ports are tied to 32'h0, no counter flops are synthesised, and all other behaviour is identical.

Test Plan:
- Reset release, req_ready=1, resp after 1 cycle with rdata=32'h0000_0413, inst_ready=1, npc=32'h8000_0004 -> req_addr=32'h8000_0000; inst_valid rises 3 cycles after reset release with inst=32'h0000_0413, pc=32'h8000_0000; next req_addr=32'h8000_0004.
- req_ready low for 4 cycles -> req_valid stays 1 and req_addr stays constant throughout; no state advance.
- inst_ready low for 5 cycles in HOLD, with resp_valid pulsed during that window and rdata=32'hDEAD_BEEF -> inst and pc unchanged, pulse ignored.
- resp_valid=1, resp_err=1 -> inst=32'h0010_0073, fetch_err=1, and fetch_err remains 1 after 3 further fetches.
- npc=32'h8000_0106 at handshake -> next req_addr=32'h8000_0104, fetch_err=1.
- rst asserted while in WAIT -> outputs return to reset values immediately; after release, a late resp_valid is ignored and the first req_addr=32'h8000_0000. With IFU_PERF_EN, 10 fetches with 2 wait cycles each -> perf_fetch_cnt=10, perf_stall_cnt=10.
